// File: rtl/bram_burst_reader_if.sv
// BRAM port-B and TX FIFO write-side signals of the burst reader.
// The reader is the master of both paths.
interface bram_burst_reader_if #(
  parameter int unsigned data_bits    = 512,
  parameter int unsigned address_bits = 10
) ();
  logic [address_bits-1:0] address_b;
  logic                    enb;
  logic                    web;
  logic [data_bits-1:0]    datain_b;
  logic [data_bits-1:0]    doutb;
  logic [data_bits-1:0]    fifo_tx_data;
  logic                    fifo_tx_valid;
  logic                    fifo_tx_ready;
  logic                    fifo_tx_last;

  modport master (
    output address_b, enb, web, datain_b, fifo_tx_data, fifo_tx_valid, fifo_tx_last,
    input  doutb, fifo_tx_ready
  );

  modport slave (
    input  address_b, enb, web, datain_b, fifo_tx_data, fifo_tx_valid, fifo_tx_last,
    output doutb, fifo_tx_ready
  );
endinterface

// File: rtl/bram_burst_reader.sv
// Streams a programmable-length burst from BRAM port B into the TX FIFO path,
// with credit-based read issue into a small FWFT buffer and last/done marking.
module bram_burst_reader #(
  parameter int unsigned data_bits    = 512,
  parameter int unsigned address_bits = 10,
  parameter int unsigned mem_depth    = 1024,
  parameter int unsigned rd_latency   = 1,
  parameter int unsigned len_bits     = 11,
  parameter int unsigned buf_depth    = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start_rd_en,
  input  logic [address_bits-1:0] address_input,
  input  logic [len_bits-1:0]     burst_len,
  output logic                    busy,
  output logic                    done,
  bram_burst_reader_if.master     bus
);

  localparam int unsigned ptr_w = $clog2(buf_depth);
  localparam int unsigned cnt_w = ptr_w + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic [address_bits-1:0] addr_q, addr_d;
  logic [len_bits-1:0]     rem_q, rem_d;
  logic                    issue;
  logic                    credit_ok;

  logic [rd_latency-1:0]   pipe_vld_q, pipe_last_q;
  logic [cnt_w:0]          inflight;

  logic [data_bits-1:0]    buf_data_q [buf_depth];
  logic [buf_depth-1:0]    buf_last_q;
  logic [ptr_w-1:0]        wr_ptr_q, rd_ptr_q;
  logic [cnt_w-1:0]        count_q;
  logic                    push, pop, head_last;

  // Credit covers words still in the BRAM pipeline plus words already buffered.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < rd_latency; i++) begin
      inflight = inflight + {{cnt_w{1'b0}}, pipe_vld_q[i]};
    end
  end

  assign credit_ok = ({1'b0, count_q} + inflight) < (cnt_w + 1)'(buf_depth);
  assign push      = pipe_vld_q[rd_latency-1];
  assign pop       = (count_q != '0) && bus.fifo_tx_ready;
  assign head_last = buf_last_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_rd_en) begin
          if (burst_len != '0) begin
            state_d = StIssue;
            addr_d  = address_input;
            rem_d   = burst_len;
          end else begin
            state_d = StDone;
          end
        end
      end
      StIssue: begin
        if (rem_q != '0 && credit_ok) begin
          issue  = 1'b1;
          addr_d = (addr_q == address_bits'(mem_depth - 1)) ? '0 : addr_q + 1'b1;
          rem_d  = rem_q - len_bits'(1);
          if (rem_q == len_bits'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && head_last) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  // Read tag pipeline aligned with the BRAM latency; the final stage marks capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      pipe_vld_q[0]  <= issue;
      pipe_last_q[0] <= issue && (rem_q == len_bits'(1));
      for (int i = 1; i < rd_latency; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < buf_depth; i++) buf_data_q[i] <= '0;
      buf_last_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= bus.doutb;
        buf_last_q[wr_ptr_q] <= pipe_last_q[rd_latency-1];
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + cnt_w'(push) - cnt_w'(pop);
    end
  end

  assign bus.address_b     = addr_q;
  assign bus.enb           = issue;
  assign bus.web           = 1'b0;
  assign bus.datain_b      = '0;
  assign bus.fifo_tx_valid = (count_q != '0);
  assign bus.fifo_tx_data  = buf_data_q[rd_ptr_q];
  assign bus.fifo_tx_last  = (count_q != '0) && head_last;
  assign busy              = (state_q == StIssue) || (state_q == StDrain);
  assign done              = (state_q == StDone);

endmodule
